// File: rtl/hdmi_packet_pkg.sv
// Shared HDMI data-island packet constants, types and BCH helper.
// Used by the packet serializer and the TERC4/BCH checker.
package hdmi_packet_pkg;

   localparam int PACKET_PIXELS    = 32;
   localparam int HEADER_DATA_BITS = 24;
   localparam int SUB_DATA_BITS    = 56;
   localparam int NUM_SUBPACKETS   = 4;

   typedef logic [SUB_DATA_BITS-1:0] sub_t;

   // One LSB-first serial BCH update with data bit d.
   function automatic logic [7:0] bch_step(
      input logic [7:0] ecc,
      input logic       d,
      input logic [7:0] poly
   );
      return (ecc >> 1) ^ ((ecc[0] ^ d) ? poly : 8'h00);
   endfunction

endpackage

// File: rtl/bch_serial_ecc.sv
// Serial BCH parity register, 1 or 2 data bits per cycle.
// Ports: step enable, seed (start from 0), freeze, clear, data, ecc.
module bch_serial_ecc
   import hdmi_packet_pkg::*;
#(
   parameter logic [7:0] POLY = 8'h83,
   parameter int         BITS = 1
) (
   input  logic       clk_pixel,
   input  logic       reset_n,
   input  logic       step,
   input  logic       seed,
   input  logic       freeze,
   input  logic       clear,
   input  logic [1:0] data,
   output logic [7:0] ecc
);

   logic [7:0] base;
   logic [7:0] s1;
   logic [7:0] s2;

   // data[0] is always consumed first (even bit in 2-bit mode).
   always_comb begin
      base = seed ? 8'h00 : ecc;
      s1   = bch_step(base, data[0], POLY);
      s2   = (BITS == 2) ? bch_step(s1, data[1], POLY) : s1;
   end

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         ecc <= 8'h00;
      end else if (clear) begin
         ecc <= 8'h00;
      end else if (step && !freeze) begin
         ecc <= s2;
      end
   end

endmodule

// File: rtl/packet_serializer.sv
// Streams a 24-bit header and four 56-bit subpackets as a 32-pixel
// data-island packet with BCH parity. Ports: enable, header, sub in;
// packet_data/valid/last/next/abort out, all registered.
module packet_serializer
   import hdmi_packet_pkg::*;
#(
   parameter logic [7:0] ECC_POLY     = 8'h83,
   parameter bit         ABORT_ON_GAP = 1'b1
) (
   input  logic                           clk_pixel,
   input  logic                           reset_n,
   input  logic                           data_island_period,
   input  logic [HEADER_DATA_BITS-1:0]    header,
   input  sub_t [NUM_SUBPACKETS-1:0]      sub,
   output logic [8:0]                     packet_data,
   output logic                           packet_valid,
   output logic                           packet_last,
   output logic                           packet_next,
   output logic                           packet_abort
);

   logic [4:0]                      cnt;
   logic [HEADER_DATA_BITS-1:0]     hdr_sh;
   sub_t [NUM_SUBPACKETS-1:0]       sub_sh;
   logic [HEADER_DATA_BITS-1:0]     hdr_src;
   sub_t [NUM_SUBPACKETS-1:0]       sub_src;
   logic [7:0]                      ecc_h;
   logic [NUM_SUBPACKETS-1:0][7:0]  ecc_s;
   logic [8:0]                      slice;
   logic                            first;
   logic                            hdr_par;
   logic                            sub_par;
   logic                            gap_abort;

   assign first     = (cnt == 5'd0);
   assign hdr_par   = (cnt >= 5'd24);
   assign sub_par   = (cnt >= 5'd28);
   assign gap_abort = ABORT_ON_GAP && !data_island_period && !first;

   // Pixel 0 reads the live inputs; later pixels read the shadows.
   assign hdr_src = first ? header : hdr_sh;
   assign sub_src = first ? sub : sub_sh;

   bch_serial_ecc #(
      .POLY (ECC_POLY),
      .BITS (1)
   ) u_ecc_h (
      .clk_pixel (clk_pixel),
      .reset_n   (reset_n),
      .step      (data_island_period),
      .seed      (first),
      .freeze    (hdr_par),
      .clear     (gap_abort),
      .data      ({1'b0, hdr_src[cnt]}),
      .ecc       (ecc_h)
   );

   for (genvar i = 0; i < NUM_SUBPACKETS; i++) begin : g_sub
      bch_serial_ecc #(
         .POLY (ECC_POLY),
         .BITS (2)
      ) u_ecc_s (
         .clk_pixel (clk_pixel),
         .reset_n   (reset_n),
         .step      (data_island_period),
         .seed      (first),
         .freeze    (sub_par),
         .clear     (gap_abort),
         .data      ({sub_src[i][{cnt, 1'b1}],
                      sub_src[i][{cnt, 1'b0}]}),
         .ecc       (ecc_s[i])
      );
   end

   // Parity pixels index the frozen ECC with the low counter bits:
   // 24..31 -> 0..7 for the header, 28..31 -> 0..3 pairs for subs.
   always_comb begin
      slice    = '0;
      slice[0] = hdr_par ? ecc_h[cnt[2:0]] : hdr_src[cnt];
      for (int i = 0; i < NUM_SUBPACKETS; i++) begin
         slice[1+i] = sub_par ? ecc_s[i][{cnt[1:0], 1'b0}]
                              : sub_src[i][{cnt, 1'b0}];
         slice[5+i] = sub_par ? ecc_s[i][{cnt[1:0], 1'b1}]
                              : sub_src[i][{cnt, 1'b1}];
      end
   end

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         cnt          <= '0;
         hdr_sh       <= '0;
         sub_sh       <= '0;
         packet_data  <= '0;
         packet_valid <= 1'b0;
         packet_last  <= 1'b0;
         packet_next  <= 1'b0;
         packet_abort <= 1'b0;
      end else if (data_island_period) begin
         packet_data  <= slice;
         packet_valid <= 1'b1;
         packet_last  <= (cnt == 5'd31);
         packet_next  <= (cnt == 5'd31);
         packet_abort <= 1'b0;
         cnt          <= cnt + 5'd1;
         if (first) begin
            hdr_sh <= header;
            sub_sh <= sub;
         end
      end else begin
         packet_data  <= '0;
         packet_valid <= 1'b0;
         packet_last  <= 1'b0;
         packet_next  <= 1'b0;
         packet_abort <= gap_abort;
         if (gap_abort) begin
            cnt    <= '0;
            hdr_sh <= '0;
            sub_sh <= '0;
         end
      end
   end

endmodule

// File: tb/tb_packet_serializer.sv
// Self-checking bench for packet_serializer: codeword-level model,
// directed packets with literal parity checks, and random traffic.
module tb_packet_serializer;

   logic              clk_pixel = 1'b0;
   logic              reset_n;
   logic              data_island_period;
   logic [23:0]       header;
   logic [3:0][55:0]  sub;
   logic [8:0]        packet_data;
   logic              packet_valid;
   logic              packet_last;
   logic              packet_next;
   logic              packet_abort;

   int total = 0;
   int bad   = 0;

   int         m_cnt;
   logic [8:0] m_slice [32];
   logic [8:0] e_data;
   logic       e_valid, e_last, e_next, e_abort;

   always #5 clk_pixel = ~clk_pixel;

   packet_serializer dut (
      .clk_pixel          (clk_pixel),
      .reset_n            (reset_n),
      .data_island_period (data_island_period),
      .header             (header),
      .sub                (sub),
      .packet_data        (packet_data),
      .packet_valid       (packet_valid),
      .packet_last        (packet_last),
      .packet_next        (packet_next),
      .packet_abort       (packet_abort)
   );

   // Parity of the first n bits of d, fed LSB first.
   function automatic logic [7:0] ref_ecc(input logic [63:0] d,
                                          input int n);
      logic [7:0] r;
      logic       fb;
      r = 8'h00;
      for (int i = 0; i < n; i++) begin
         fb = r[0] ^ d[i];
         r  = r >> 1;
         if (fb) r = r ^ 8'h83;
      end
      return r;
   endfunction

   function automatic logic [55:0] rnd56();
      logic [63:0] v;
      v = {$urandom, $urandom};
      return v[55:0];
   endfunction

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   // Build the 32 expected slices from the full codewords.
   task automatic build();
      logic [31:0] hb;
      logic [63:0] sb [4];
      hb = {ref_ecc({40'h0, header}, 24), header};
      for (int i = 0; i < 4; i++)
         sb[i] = {ref_ecc({8'h0, sub[i]}, 56), sub[i]};
      for (int c = 0; c < 32; c++) begin
         m_slice[c][0] = hb[c];
         for (int i = 0; i < 4; i++) begin
            m_slice[c][1+i] = sb[i][2*c];
            m_slice[c][5+i] = sb[i][2*c+1];
         end
      end
   endtask

   task automatic model_reset();
      m_cnt   = 0;
      e_data  = '0;
      e_valid = 1'b0;
      e_last  = 1'b0;
      e_next  = 1'b0;
      e_abort = 1'b0;
   endtask

   task automatic compare();
      check("data",  {23'h0, packet_data},  {23'h0, e_data});
      check("valid", {31'h0, packet_valid}, {31'h0, e_valid});
      check("last",  {31'h0, packet_last},  {31'h0, e_last});
      check("next",  {31'h0, packet_next},  {31'h0, e_next});
      check("abort", {31'h0, packet_abort}, {31'h0, e_abort});
   endtask

   // One clock: update the model from the inputs seen at the edge,
   // then compare just after the edge.
   task automatic step();
      @(posedge clk_pixel);
      if (!reset_n) begin
         model_reset();
      end else if (data_island_period) begin
         if (m_cnt == 0) build();
         e_data  = m_slice[m_cnt];
         e_valid = 1'b1;
         e_last  = (m_cnt == 31);
         e_next  = (m_cnt == 31);
         e_abort = 1'b0;
         m_cnt   = (m_cnt + 1) % 32;
      end else begin
         e_data  = '0;
         e_valid = 1'b0;
         e_last  = 1'b0;
         e_next  = 1'b0;
         e_abort = (m_cnt != 0);
         m_cnt   = 0;
      end
      #1;
      compare();
   endtask

   initial begin
      logic [7:0] lit;
      reset_n            = 1'b0;
      data_island_period = 1'b0;
      header             = '0;
      sub                = '0;
      model_reset();
      repeat (2) @(posedge clk_pixel);
      #1;
      compare();
      reset_n = 1'b1;

      // Model pin: known parity of a single set header bit.
      check("ref_ecc", {24'h0, ref_ecc(64'h80_0000, 24)}, 32'h83);

      // Null packet.
      data_island_period = 1'b1;
      for (int k = 0; k < 32; k++) begin
         step();
         check("null_data", {23'h0, packet_data}, 32'h0);
         check("null_next", {31'h0, packet_next},
               (k == 31) ? 32'h1 : 32'h0);
      end

      // Header MSB only: parity 8'h83 on pixels 24..31.
      header = 24'h800000;
      lit    = 8'h83;
      for (int k = 0; k < 32; k++) begin
         step();
         if (k < 24)
            check("hdr_bit", {31'h0, packet_data[0]},
                  (k == 23) ? 32'h1 : 32'h0);
         else
            check("hdr_par", {31'h0, packet_data[0]},
                  {31'h0, lit[k-24]});
      end

      // sub[0] MSB only.
      header = '0;
      sub[0] = 56'h80_0000_0000_0000;
      for (int k = 0; k < 32; k++) begin
         step();
         if (k == 27)
            check("sub_bit", {30'h0, packet_data[1], packet_data[5]},
                  32'h1);
         if (k >= 28)
            check("sub_par", {30'h0, packet_data[1], packet_data[5]},
                  {30'h0, lit[2*(k-28)], lit[2*(k-28)+1]});
      end

      // Inputs change at pixel 5; model keeps the pixel-0 capture.
      header = 24'hA5C3F1;
      for (int i = 0; i < 4; i++) sub[i] = rnd56();
      for (int k = 0; k < 32; k++) begin
         if (k == 5) begin
            header = ~header;
            for (int i = 0; i < 4; i++) sub[i] = rnd56();
         end
         step();
      end

      // Gap at pixel 10 aborts; next packet starts fresh.
      header = 24'h123456;
      for (int k = 0; k < 10; k++) step();
      data_island_period = 1'b0;
      step();
      check("abort_pulse", {31'h0, packet_abort}, 32'h1);
      check("abort_next",  {31'h0, packet_next},  32'h0);
      step();
      check("abort_once",  {31'h0, packet_abort}, 32'h0);
      data_island_period = 1'b1;
      header = 24'h0F0F0F;
      for (int i = 0; i < 4; i++) sub[i] = rnd56();
      for (int k = 0; k < 32; k++) step();

      // Reset at pixel 15.
      for (int k = 0; k < 16; k++) step();
      #3;
      reset_n = 1'b0;
      #1;
      model_reset();
      compare();
      step();
      #2;
      reset_n = 1'b1;

      // 64 back-to-back pixels after release.
      header = 24'hFEDCBA;
      for (int i = 0; i < 4; i++) sub[i] = rnd56();
      for (int k = 0; k < 64; k++) begin
         if (k == 40) begin
            header = 24'h00FF00;
            for (int i = 0; i < 4; i++) sub[i] = rnd56();
         end
         step();
         if (k == 31 || k == 63)
            check("b2b_next", {31'h0, packet_next}, 32'h1);
      end

      // Random traffic with gaps and changing inputs.
      for (int k = 0; k < 1500; k++) begin
         data_island_period = ($urandom_range(0, 24) != 0);
         if ($urandom_range(0, 3) == 0) begin
            header = 24'($urandom);
            for (int i = 0; i < 4; i++) sub[i] = rnd56();
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/packet_serializer.md
Name: packet_serializer

Overview:
- Downstream of the packet-type selector. Takes the selected 24-bit header and four 56-bit subpackets and streams them out as a 32-pixel HDMI data-island packet, one 9-bit slice per pixel clock.
- Adds the BCH parity on the fly: BCH(32,24) for the header and BCH(64,56) for each subpacket.
- Tells upstream when it may present the next packet, and feeds the TERC4 encoder stage.

Parameters:
- ECC_POLY, 8'h83, feedback mask for the serial BCH update (HDMI generator 1+x^6+x^7+x^8, LSB-first form).
- ABORT_ON_GAP, 1, 1 = a drop of data_island_period mid-packet aborts the packet; 0 = the counter holds and resumes.

Ports:
- clk_pixel  input  1  pixel clock; sole clock.
- reset_n  input  1  asynchronous active-low reset.
- data_island_period  input  1  high while data-island packet pixels are being emitted.
- header  input  24  packet header from the selector.
- sub  input  4x56  subpackets 0..3 from the selector.
- packet_data  output  9  bit 0 = header bit; bits 1..4 = sub[0..3] even bit; bits 5..8 = sub[0..3] odd bit.
- packet_valid  output  1  packet_data holds a valid packet bit.
- packet_last  output  1  packet_data holds pixel 31.
- packet_next  output  1  one-cycle pulse: packet consumed, upstream may advance.
- packet_abort  output  1  one-cycle pulse: packet truncated by a gap.

Behaviour:
- Reset (async assert, sync release): all outputs 0; counter 0; shadows and ECC registers 0.
- counter[4:0] advances on each edge with data_island_period=1 and wraps 31->0.
- Edge with counter==0 and enable high:
  - captures header/sub into shadow registers;
  - bit 0 is taken from the live inputs;
  - ECC registers are seeded from 0.
- Later pixels use the shadows only, so upstream may change inputs after pixel 0.
- Source slice at counter c:
  - header: c<24 -> header[c]; c>=24 -> ecc_h[c-24].
  - sub i: c<28 -> bit[2c] and bit[2c+1]; c>=28 -> ecc_s[i][2(c-28)] and ecc_s[i][2(c-28)+1].
- ECC step per data bit b: ecc = (ecc>>1) ^ ((ecc[0]^b) ? ECC_POLY : 0).
  - Header: one step per pixel for c<24; register frozen from c=24 on.
  - Subpackets: two steps per pixel (even bit first, then odd) for c<28; frozen from c=28 on.
- Parity pixels output the frozen value and do not update it.
- Latency: 1 cycle. The slice for counter c appears on packet_data at the edge where the counter moves from c; packet_valid=1 in the same cycle.
- Pixel 31 registered: packet_last=1 and packet_next=1 for exactly one cycle.
- Back-to-back packets: counter wraps to 0 and a new capture occurs with no idle cycle.
- Enable low:
  - packet_valid=0 and packet_data=0 next cycle.
  - If the counter is nonzero and ABORT_ON_GAP=1: counter, ECC and shadows clear, packet_abort pulses one cycle, packet_next stays 0.
  - If ABORT_ON_GAP=0: all state holds.
  - If the counter is 0: no abort.
- Reset mid-packet: immediate return to reset values; no packet_next and no packet_abort.

Decomposition:
- Shared package hdmi_packet_pkg holds:
  - constants PACKET_PIXELS=32, HEADER_DATA_BITS=24, SUB_DATA_BITS=56, NUM_SUBPACKETS=4;
  - typedef sub_t (logic [55:0]);
  - function bch_step(ecc, bit, poly), shared with the TERC4/BCH checker.
- One natural sub-module: bch_serial_ecc, a single ECC register with a 1- or 2-bit-per-cycle step and a freeze input.
  - Instantiated 5x: header in 1-bit mode, subpackets in 2-bit mode.

Test Plan:
- Null packet: header=0, sub=0 for 32 enabled cycles -> packet_data=0 on every pixel (parity included); packet_last and packet_next high only on pixel 31.
- Header=24'h800000, sub=0 -> bit 0 is 1 only at pixel 23; pixels 24..31 give bit 0 = 1,1,0,0,0,0,0,1 (ecc 8'h83).
- sub[0]=56'h80_0000_0000_0000, rest 0 -> bit 5 =1 at pixel 27; pixels 28..31 give {bit1,bit5} = {1,1},{0,0},{0,0},{0,1}.
- Change header/sub inputs at pixel 5 -> output stream identical to the unchanged case (shadow capture).
- Drop enable at pixel 10, ABORT_ON_GAP=1 -> one-cycle packet_abort, no packet_next; the next enable starts at pixel 0 with fresh capture and correct ECC.
- Assert reset_n=0 at pixel 15 -> outputs 0 asynchronously; after release, a full 64-pixel back-to-back run matches the reference model, with packet_next at pixels 31 and 63.
